rob_multi: RTL and testbench

Parametrised reorder buffer for the out-of-order core: a circular buffer of ROB_DEPTH entries that allocates in program order at dispatch and accepts results from CDB_PORTS completion buses per cycle. It also tracks store addresses for load disambiguation, retires one entry per cycle under a commit handshake, and flushes all speculative state when a mispredicted branch reaches the head. It sits between dispatch, the CDB, the load/store unit and the architectural register file/memory commit path.

---
 rtl/rob_multi.sv | 181 ++++++++++++++++++
 tb/tb_rob_multi.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi.sv
// rob_multi: reorder buffer. Allocation happens in program order at the tail.
// Results arrive from CDB_PORTS completion buses per cycle. Store addresses are
// tracked so that loads can be checked against older stores. Entries retire
// from the head one per cycle. A mispredicted branch at the head flushes the
// whole buffer.
module rob_multi #(
  parameter int XLEN      = 32,
  parameter int ROB_DEPTH = 8,
  parameter int TAG_LEN   = $clog2(ROB_DEPTH),
  parameter int CDB_PORTS = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           alloc_enable,
  input  logic                           alloc_wr_mem,
  input  logic [4:0]                     alloc_dest_reg,
  input  logic [CDB_PORTS-1:0]           cdb_valid,
  input  logic [CDB_PORTS*TAG_LEN-1:0]   cdb_tag,
  input  logic [CDB_PORTS*XLEN-1:0]      cdb_value,
  input  logic [CDB_PORTS-1:0]           cdb_mispredict,
  input  logic                           st_addr_valid,
  input  logic [TAG_LEN-1:0]             st_addr_tag,
  input  logic [XLEN-1:0]                st_addr,
  input  logic [TAG_LEN-1:0]             read_rob_tag,
  input  logic [TAG_LEN-1:0]             load_rob_tag,
  input  logic [XLEN-1:0]                load_address,
  input  logic                           commit_enable,
  output logic                           full,
  output logic                           empty,
  output logic [TAG_LEN-1:0]             alloc_slot,
  output logic [XLEN-1:0]                read_value,
  output logic                           read_ready,
  output logic                           pending_stores,
  output logic                           commit_ready,
  output logic [XLEN-1:0]                commit_value,
  output logic [4:0]                     commit_dest_reg,
  output logic [XLEN-1:0]                commit_dest_addr,
  output logic                           commit_wr_mem,
  output logic                           flush
);

  localparam logic [TAG_LEN:0]   DEPTH_CNT = (TAG_LEN+1)'(ROB_DEPTH);
  localparam logic [TAG_LEN:0]   CNT_ONE   = (TAG_LEN+1)'(1);
  localparam logic [TAG_LEN-1:0] TAG_ONE   = TAG_LEN'(1);

  logic [ROB_DEPTH-1:0] e_valid;
  logic [ROB_DEPTH-1:0] e_ready;
  logic [ROB_DEPTH-1:0] e_wr_mem;
  logic [ROB_DEPTH-1:0] e_addr_valid;
  logic [ROB_DEPTH-1:0] e_mispredict;
  logic [4:0]           e_dest  [ROB_DEPTH];
  logic [XLEN-1:0]      e_value [ROB_DEPTH];
  logic [XLEN-1:0]      e_addr  [ROB_DEPTH];

  logic [TAG_LEN-1:0] head;
  logic [TAG_LEN-1:0] tail;
  logic [TAG_LEN:0]   count;

  logic               do_alloc;
  logic               do_commit;
  logic [TAG_LEN-1:0] walk_idx [ROB_DEPTH];

  assign full       = (count == DEPTH_CNT);
  assign empty      = (count == '0);
  assign alloc_slot = tail;

  // Head retirement handshake. full is sampled before this cycle's commit,
  // so a full buffer never allocates, even while it is retiring an entry.
  always_comb begin
    commit_ready = e_valid[head] && e_ready[head] && (!e_wr_mem[head] || e_addr_valid[head]);
    do_commit    = commit_ready && commit_enable;
    flush        = do_commit && e_mispredict[head];
    do_alloc     = alloc_enable && !full && !flush;
  end

  // The commit outputs mirror the head entry and are zero when the head is empty.
  always_comb begin
    commit_value     = '0;
    commit_dest_reg  = '0;
    commit_dest_addr = '0;
    commit_wr_mem    = 1'b0;
    if (e_valid[head]) begin
      commit_value     = e_value[head];
      commit_dest_reg  = e_dest[head];
      commit_dest_addr = e_addr[head];
      commit_wr_mem    = e_wr_mem[head];
    end
  end

  // Operand lookup. A result currently on the CDB takes priority over the
  // stored entry, and the highest-numbered matching port wins.
  always_comb begin
    read_ready = 1'b0;
    read_value = '0;
    if (e_valid[read_rob_tag] && e_ready[read_rob_tag]) begin
      read_ready = 1'b1;
      read_value = e_value[read_rob_tag];
    end
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid[p] && (cdb_tag[p*TAG_LEN +: TAG_LEN] == read_rob_tag)) begin
        read_ready = 1'b1;
        read_value = cdb_value[p*XLEN +: XLEN];
      end
    end
  end

  // Buffer slots in age order, starting from the head and wrapping around.
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) begin
      walk_idx[i] = head + TAG_LEN'(i);
    end
  end

  // Load disambiguation. Walk the slots from the head until the load's own
  // slot is reached. Any older store whose address is still unknown, or whose
  // address equals the load address, makes the load wait.
  always_comb begin
    logic reached;
    reached        = 1'b0;
    pending_stores = 1'b0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      if (walk_idx[i] == load_rob_tag) reached = 1'b1;
      if (!reached && e_valid[walk_idx[i]] && e_wr_mem[walk_idx[i]] &&
          (!e_addr_valid[walk_idx[i]] || (e_addr[walk_idx[i]] == load_address)))
        pending_stores = 1'b1;
    end
  end

  // Entry state, pointers and count. A flush overrides every other update
  // made in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      e_valid      <= '0;
      e_ready      <= '0;
      e_wr_mem     <= '0;
      e_addr_valid <= '0;
      e_mispredict <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        e_dest[i]  <= '0;
        e_value[i] <= '0;
        e_addr[i]  <= '0;
      end
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      e_valid <= '0;
    end else begin
      if (do_alloc) begin
        e_valid[tail]      <= 1'b1;
        e_ready[tail]      <= 1'b0;
        e_addr_valid[tail] <= 1'b0;
        e_mispredict[tail] <= 1'b0;
        e_wr_mem[tail]     <= alloc_wr_mem;
        e_dest[tail]       <= alloc_dest_reg;
        tail               <= tail + TAG_ONE;
      end
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (cdb_valid[p] && e_valid[cdb_tag[p*TAG_LEN +: TAG_LEN]]) begin
          e_ready[cdb_tag[p*TAG_LEN +: TAG_LEN]]      <= 1'b1;
          e_value[cdb_tag[p*TAG_LEN +: TAG_LEN]]      <= cdb_value[p*XLEN +: XLEN];
          e_mispredict[cdb_tag[p*TAG_LEN +: TAG_LEN]] <= cdb_mispredict[p];
        end
      end
      if (st_addr_valid && e_valid[st_addr_tag] && e_wr_mem[st_addr_tag]) begin
        e_addr[st_addr_tag]       <= st_addr;
        e_addr_valid[st_addr_tag] <= 1'b1;
      end
      if (do_commit) begin
        e_valid[head] <= 1'b0;
        head          <= head + TAG_ONE;
      end
      if (do_alloc && !do_commit)      count <= count + CNT_ONE;
      else if (!do_alloc && do_commit) count <= count - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi: directed test of rob_multi with a commit scoreboard.
module tb_rob_multi;
  localparam int XLEN = 32;
  localparam int ROB_DEPTH = 8;
  localparam int TAG_LEN = 3;
  localparam int CDB_PORTS = 2;

  logic                         clock = 1'b0;
  logic                         reset;
  logic                         alloc_enable;
  logic                         alloc_wr_mem;
  logic [4:0]                   alloc_dest_reg;
  logic [CDB_PORTS-1:0]         cdb_valid;
  logic [CDB_PORTS*TAG_LEN-1:0] cdb_tag;
  logic [CDB_PORTS*XLEN-1:0]    cdb_value;
  logic [CDB_PORTS-1:0]         cdb_mispredict;
  logic                         st_addr_valid;
  logic [TAG_LEN-1:0]           st_addr_tag;
  logic [XLEN-1:0]              st_addr;
  logic [TAG_LEN-1:0]           read_rob_tag;
  logic [TAG_LEN-1:0]           load_rob_tag;
  logic [XLEN-1:0]              load_address;
  logic                         commit_enable;
  logic                         full, empty;
  logic [TAG_LEN-1:0]           alloc_slot;
  logic [XLEN-1:0]              read_value;
  logic                         read_ready;
  logic                         pending_stores;
  logic                         commit_ready;
  logic [XLEN-1:0]              commit_value;
  logic [4:0]                   commit_dest_reg;
  logic [XLEN-1:0]              commit_dest_addr;
  logic                         commit_wr_mem;
  logic                         flush;

  rob_multi #(.XLEN(XLEN), .ROB_DEPTH(ROB_DEPTH), .TAG_LEN(TAG_LEN), .CDB_PORTS(CDB_PORTS)) dut (
    .clock(clock), .reset(reset),
    .alloc_enable(alloc_enable), .alloc_wr_mem(alloc_wr_mem), .alloc_dest_reg(alloc_dest_reg),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_mispredict(cdb_mispredict),
    .st_addr_valid(st_addr_valid), .st_addr_tag(st_addr_tag), .st_addr(st_addr),
    .read_rob_tag(read_rob_tag), .load_rob_tag(load_rob_tag), .load_address(load_address),
    .commit_enable(commit_enable),
    .full(full), .empty(empty), .alloc_slot(alloc_slot),
    .read_value(read_value), .read_ready(read_ready), .pending_stores(pending_stores),
    .commit_ready(commit_ready), .commit_value(commit_value), .commit_dest_reg(commit_dest_reg),
    .commit_dest_addr(commit_dest_addr), .commit_wr_mem(commit_wr_mem), .flush(flush)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [TAG_LEN-1:0] tag;
    logic [4:0]         dest;
    logic               wr_mem;
  } rec_t;

  rec_t               sb[$];
  logic [XLEN-1:0]    exp_val  [ROB_DEPTH];
  logic [XLEN-1:0]    exp_addr [ROB_DEPTH];
  logic [TAG_LEN-1:0] tail_m;
  int                 n_assert = 0;
  int                 n_fail = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_cdb();
    cdb_valid = '0;
    cdb_tag = '0;
    cdb_value = '0;
    cdb_mispredict = '0;
  endtask

  task automatic drive_cdb(input int p, input logic [TAG_LEN-1:0] tag, input logic [XLEN-1:0] val,
                           input logic mis);
    cdb_valid[p] = 1'b1;
    cdb_tag[p*TAG_LEN +: TAG_LEN] = tag;
    cdb_value[p*XLEN +: XLEN] = val;
    cdb_mispredict[p] = mis;
    exp_val[tag] = val;
  endtask

  // Allocate one entry and record it on the scoreboard in program order.
  task automatic alloc_one(input logic [4:0] dest, input logic wr);
    rec_t r;
    alloc_enable = 1'b1;
    alloc_dest_reg = dest;
    alloc_wr_mem = wr;
    #1;
    chk("alloc_slot", 32'(alloc_slot), 32'(tail_m));
    r.tag = tail_m;
    r.dest = dest;
    r.wr_mem = wr;
    sb.push_back(r);
    tail_m = tail_m + 3'd1;
    tick();
    alloc_enable = 1'b0;
  endtask

  // Retire the head and compare it with the oldest entry on the scoreboard.
  task automatic commit_one();
    rec_t r;
    #1;
    chk("commit_ready", 32'(commit_ready), 32'd1);
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      r = sb.pop_front();
      chk("commit_dest_reg", 32'(commit_dest_reg), 32'(r.dest));
      chk("commit_wr_mem", 32'(commit_wr_mem), 32'(r.wr_mem));
      chk("commit_value", commit_value, exp_val[r.tag]);
      if (r.wr_mem) chk("commit_dest_addr", commit_dest_addr, exp_addr[r.tag]);
    end
    commit_enable = 1'b1;
    tick();
    commit_enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    alloc_enable = 1'b0;
    alloc_wr_mem = 1'b0;
    alloc_dest_reg = '0;
    clear_cdb();
    st_addr_valid = 1'b0;
    st_addr_tag = '0;
    st_addr = '0;
    read_rob_tag = '0;
    load_rob_tag = '0;
    load_address = '0;
    commit_enable = 1'b0;
    tail_m = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      exp_val[i] = '0;
      exp_addr[i] = '0;
    end

    // Reset defaults.
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_alloc_slot", 32'(alloc_slot), 32'd0);
    chk("rst_commit_ready", 32'(commit_ready), 32'd0);
    chk("rst_commit_value", commit_value, 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_pending", 32'(pending_stores), 32'd0);
    chk("rst_read_ready", 32'(read_ready), 32'd0);
    chk("rst_read_value", read_value, 32'd0);

    // Fill the buffer. Tag 1 is a store, and entry i writes register i+1.
    for (int i = 0; i < ROB_DEPTH; i++) alloc_one(5'(i + 1), (i == 1));
    chk("full_after_8", 32'(full), 32'd1);
    chk("full_alloc_slot", 32'(alloc_slot), 32'd0);
    alloc_enable = 1'b1;
    alloc_dest_reg = 5'd31;
    tick();
    alloc_enable = 1'b0;
    chk("ninth_dropped_full", 32'(full), 32'd1);
    chk("ninth_dropped_slot", 32'(alloc_slot), 32'd0);
    chk("head_not_ready", 32'(commit_ready), 32'd0);

    // CDB writes on both ports, with the bypass visible in the same cycle.
    drive_cdb(0, 3'd3, 32'hAA, 1'b0);
    drive_cdb(1, 3'd5, 32'hBB, 1'b0);
    read_rob_tag = 3'd3;
    #1;
    chk("bypass_rdy_3", 32'(read_ready), 32'd1);
    chk("bypass_val_3", read_value, 32'hAA);
    tick();
    clear_cdb();
    #1;
    chk("read_rdy_3", 32'(read_ready), 32'd1);
    chk("read_val_3", read_value, 32'hAA);
    read_rob_tag = 3'd5;
    #1;
    chk("read_val_5", read_value, 32'hBB);
    read_rob_tag = 3'd4;
    #1;
    chk("read_rdy_4_not", 32'(read_ready), 32'd0);
    chk("read_val_4_zero", read_value, 32'd0);

    // When both ports carry the same tag, port 1 wins.
    drive_cdb(0, 3'd2, 32'h1, 1'b0);
    drive_cdb(1, 3'd2, 32'h2, 1'b0);
    read_rob_tag = 3'd2;
    #1;
    chk("bypass_dup_val", read_value, 32'h2);
    tick();
    clear_cdb();
    #1;
    chk("dup_tag_val", read_value, 32'h2);

    // Load disambiguation against the store at tag 1.
    load_rob_tag = 3'd2;
    load_address = 32'h100;
    #1;
    chk("pend_addr_unknown", 32'(pending_stores), 32'd1);
    st_addr_valid = 1'b1;
    st_addr_tag = 3'd1;
    st_addr = 32'h100;
    exp_addr[1] = 32'h100;
    tick();
    st_addr_valid = 1'b0;
    #1;
    chk("pend_addr_match", 32'(pending_stores), 32'd1);
    load_address = 32'h104;
    #1;
    chk("pend_addr_differ", 32'(pending_stores), 32'd0);
    load_rob_tag = 3'd1;
    load_address = 32'h100;
    #1;
    chk("pend_not_older", 32'(pending_stores), 32'd0);

    // Complete the head. It becomes ready the cycle after the edge, and it
    // holds while commit_enable stays low.
    drive_cdb(0, 3'd0, 32'h10, 1'b0);
    drive_cdb(1, 3'd1, 32'h11, 1'b0);
    #1;
    chk("latency_not_yet", 32'(commit_ready), 32'd0);
    tick();
    clear_cdb();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", 32'(commit_ready), 32'd1);
      chk("hold_head", 32'(commit_dest_reg), 32'd1);
      tick();
    end
    for (int i = 0; i < 4; i++) commit_one();

    // Allocate two more entries; the tail wraps to tags 0 and 1.
    alloc_one(5'd9, 1'b0);
    alloc_one(5'd10, 1'b0);
    drive_cdb(0, 3'd4, 32'h44, 1'b0);
    drive_cdb(1, 3'd6, 32'h66, 1'b0);
    tick();
    clear_cdb();
    drive_cdb(0, 3'd7, 32'h77, 1'b0);
    drive_cdb(1, 3'd0, 32'h90, 1'b0);
    tick();
    clear_cdb();
    drive_cdb(0, 3'd1, 32'hA0, 1'b0);
    tick();
    clear_cdb();
    for (int i = 0; i < 6; i++) commit_one();
    chk("drained_empty", 32'(empty), 32'd1);
    chk("drained_sb", 32'(sb.size()), 32'd0);

    // A mispredicted branch at the head, with four younger entries behind it.
    alloc_one(5'd0, 1'b0);
    for (int i = 0; i < 4; i++) alloc_one(5'(20 + i), 1'b0);
    chk("pre_flush_slot", 32'(alloc_slot), 32'd7);
    drive_cdb(0, 3'd2, 32'h4000, 1'b1);
    tick();
    clear_cdb();
    alloc_enable = 1'b1;
    alloc_dest_reg = 5'd30;
    commit_enable = 1'b1;
    #1;
    chk("flush_asserted", 32'(flush), 32'd1);
    chk("flush_value", commit_value, 32'h4000);
    tick();
    alloc_enable = 1'b0;
    commit_enable = 1'b0;
    sb.delete();
    tail_m = '0;
    #1;
    chk("post_flush_empty", 32'(empty), 32'd1);
    chk("post_flush_slot", 32'(alloc_slot), 32'd0);
    chk("post_flush_flush", 32'(flush), 32'd0);
    read_rob_tag = 3'd3;
    #1;
    chk("post_flush_read", 32'(read_ready), 32'd0);

    // Reset in the middle of operation.
    for (int i = 0; i < 5; i++) alloc_one(5'(i + 11), 1'b0);
    drive_cdb(0, 3'd0, 32'h55, 1'b0);
    tick();
    clear_cdb();
    #1;
    chk("mid_ready", 32'(commit_ready), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_ready", 32'(commit_ready), 32'd0);
    chk("mid_rst_slot", 32'(alloc_slot), 32'd0);
    chk("mid_rst_value", commit_value, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
